// File: rtl/sipo_ctrl.sv
// Frame controller for a serial-in/parallel-out receiver: clears and shifts an
// internal register, counts bits, and hands finished words to a valid/ready consumer.
//
// state | meaning
// IDLE  | waiting for start
// CLR   | one-cycle clear of shift register and bit counter
// SHIFT | accepting bits on si_valid until WIDTH bits are in
// DONE  | one-cycle hand-off of the word (or drop with overrun)
module sipo_ctrl #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             start,
  input  logic             si,
  input  logic             si_valid,
  input  logic             abort,
  input  logic             clr_ovr,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             sr_shift,
  output logic             sr_clear,
  output logic             busy,
  output logic             overrun,
  output logic [4:0]       bit_cnt
);

  typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

  localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic             shift_en;
  logic             abort_en;
  logic             load_en;
  logic             drop_en;

  assign abort_en = abort && (state == CLR || state == SHIFT);
  assign shift_en = (state == SHIFT) && si_valid && !abort;
  assign load_en  = (state == DONE) && (!dout_valid || dout_ready);
  assign drop_en  = (state == DONE) && dout_valid && !dout_ready;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = CLR;
      CLR:   state_nxt = abort ? IDLE : SHIFT;
      SHIFT: begin
        if (abort)                                 state_nxt = IDLE;
        else if (si_valid && bit_cnt == LAST_BIT) state_nxt = DONE;
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sr_shift = shift_en;
    sr_clear = (state == CLR);
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      sreg <= '0;
    end else if (state == CLR) begin
      sreg <= '0;
    end else if (shift_en) begin
      if (MSB_FIRST) sreg <= {sreg[WIDTH-2:0], si};
      else           sreg <= {si, sreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)                       bit_cnt <= '0;
    else if (state == CLR || abort_en) bit_cnt <= '0;
    else if (shift_en)                 bit_cnt <= bit_cnt + 5'd1;
  end

  // A load takes precedence over a consume, so load+consume leaves the new word valid.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (load_en) begin
      dout       <= sreg;
      dout_valid <= 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)     overrun <= 1'b0;
    else if (drop_en) overrun <= 1'b1;
    else if (clr_ovr) overrun <= 1'b0;
  end

endmodule
